// File: rtl/stream_to_mem_writer.sv
`timescale 1ns/1ps
// stream_to_mem_writer: packs a byte stream little-endian into 32-bit words and writes them to an on-chip memory
module stream_to_mem_writer #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 10024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       byte_count,
    input  logic [7:0]        st_data,
    input  logic              st_valid,
    output logic              st_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              error
);
    typedef enum logic [1:0] {IDLE, FILL, WRITE, FINISH} state_t;
    state_t            state_q;
    logic [1:0]        lane_q;
    logic [15:0]       rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [3:0]        be_q;
    logic              ready_q, cs_q, we_q, busy_q, done_q, err_q, clken_q;
    logic [16:0]       words_d;
    logic [31:0]       end_d;
    logic              accept_d;
    assign words_d  = ({1'b0, byte_count} + 17'd3) >> 2;
    assign end_d    = 32'(base_addr) + 32'(words_d);
    assign accept_d = ready_q && st_valid;
    assign st_ready       = ready_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = we_q;
    assign mem_writedata  = data_q;
    assign mem_clken      = clken_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    // Transfer FSM; every output is a register updated on the transition that enters its state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            ready_q <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            clken_q <= 1'b0;
        end else begin
            clken_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        err_q   <= 1'b0;
                        addr_q  <= base_addr;
                        rem_q   <= byte_count;
                        lane_q  <= '0;
                        data_q  <= '0;
                        be_q    <= '0;
                        busy_q  <= 1'b1;
                        if (end_d > DEPTH) begin
                            err_q   <= 1'b1;
                            state_q <= FINISH;
                        end else if (byte_count == 16'd0) begin
                            state_q <= FINISH;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept_d) begin
                        data_q[{lane_q, 3'b000} +: 8] <= st_data;
                        be_q[lane_q] <= 1'b1;
                        lane_q <= lane_q + 2'd1;
                        rem_q  <= rem_q - 16'd1;
                        if (lane_q == 2'd3 || rem_q == 16'd1) begin
                            ready_q <= 1'b0;
                            cs_q    <= 1'b1;
                            we_q    <= 1'b1;
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    cs_q <= 1'b0;
                    we_q <= 1'b0;
                    if (rem_q != 16'd0) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        lane_q  <= '0;
                        data_q  <= '0;
                        be_q    <= '0;
                        ready_q <= 1'b1;
                        state_q <= FILL;
                    end else begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_to_mem_writer.sv
`timescale 1ns/1ps
// tb_stream_to_mem_writer: scoreboard bench; stimulus queues expected writes, a monitor checks each memory write
module tb_stream_to_mem_writer;
    localparam int ADDR_W = 14;
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [3:0]        be;
    } wr_t;
    logic              clk = 1'b0;
    logic              reset_n;
    logic              start = 1'b0;
    logic              st_valid = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       byte_count = '0;
    logic [7:0]        st_data = '0;
    logic              st_ready, mem_chipselect, mem_write, mem_clken, busy, done, error;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata;
    wr_t               exp_q[$];
    wr_t               exp_w;
    int                checks = 0;
    int                errors = 0;
    int                done_cnt = 0;
    int                wr_cnt = 0;
    logic              acc_q = 1'b0;

    always #5 clk = ~clk;

    stream_to_mem_writer #(.ADDR_W(ADDR_W), .DEPTH(10024)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .byte_count(byte_count), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .busy(busy), .done(done), .error(error)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, req);
        end
    endtask

    function automatic void push(input int a, input logic [31:0] d, input logic [3:0] be);
        wr_t w;
        w.a = ADDR_W'(a);
        w.d = d;
        w.be = be;
        exp_q.push_back(w);
    endfunction

    // a byte handshake at this edge; the write must follow it directly
    always @(posedge clk) acc_q <= st_valid && st_ready;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_write) begin
            wr_cnt++;
            chk("write_strobes", {30'd0, mem_chipselect, st_ready}, 32'h2);
            chk("write_latency", 32'(acc_q), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%h, expected no write", mem_address, mem_writedata);
            end else begin
                exp_w = exp_q.pop_front();
                chk("write_addr", 32'(mem_address), 32'(exp_w.a));
                chk("write_data", mem_writedata, exp_w.d);
                chk("write_be", 32'(mem_byteenable), 32'(exp_w.be));
            end
        end
    end

    task automatic send_bytes(input int n, input logic [7:0] first, input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            st_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            st_data = first + 8'(i);
            if (st_valid && st_ready) i++;
        end
        @(negedge clk);
        st_valid = 1'b0;
        chk("bytes_accepted", 32'(i), 32'(n));
    endtask

    task automatic finish_xfer(input string n, input int d0, input int w0, input int nw, input logic exp_err);
        int k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk({n, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({n, "_done_low"}, 32'(done), 32'd0);
        chk({n, "_busy"}, 32'(busy), 32'd0);
        chk({n, "_error"}, 32'(error), 32'(exp_err));
        chk({n, "_writes"}, 32'(wr_cnt - w0), 32'(nw));
        chk({n, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic xfer(input string n, input int b, input int c, input logic [7:0] first,
                        input bit gaps, input logic exp_err, input int nw);
        int d0 = done_cnt;
        int w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        base_addr = ADDR_W'(b);
        byte_count = 16'(c);
        @(negedge clk);
        start = 1'b0;
        if (!exp_err && c > 0) send_bytes(c, first, gaps);
        finish_xfer(n, d0, w0, nw, exp_err);
    endtask

    initial begin
        int d0;
        int w0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("reset_flags", {25'd0, st_ready, mem_chipselect, mem_write, busy, done, error, mem_clken}, 32'd0);
        chk("reset_addr", 32'(mem_address), 32'd0);
        chk("reset_data", mem_writedata, 32'd0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("clken_after_reset", 32'(mem_clken), 32'd1);
        chk("idle_flags", {29'd0, busy, st_ready, done}, 32'd0);

        push(0, 32'h04030201, 4'hF);
        push(1, 32'h08070605, 4'hF);
        xfer("b0_c8", 0, 8, 8'h01, 1'b0, 1'b0, 2);

        push(10, 32'h14131211, 4'hF);
        push(11, 32'h00000015, 4'h1);
        xfer("b10_c5", 10, 5, 8'h11, 1'b0, 1'b0, 2);

        d0 = done_cnt;
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        base_addr = ADDR_W'(7);
        byte_count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_busy_c1", 32'(busy), 32'd1);
        chk("zero_done_c1", 32'(done), 32'd0);
        @(negedge clk);
        chk("zero_done_c2", 32'(done), 32'd1);
        finish_xfer("zero", d0, w0, 0, 1'b0);

        xfer("range_err", 10020, 20, 8'h50, 1'b0, 1'b1, 0);
        repeat (3) @(negedge clk);
        chk("error_sticky", 32'(error), 32'd1);

        push(10020, 32'h43424140, 4'hF);
        push(10021, 32'h47464544, 4'hF);
        push(10022, 32'h4B4A4948, 4'hF);
        push(10023, 32'h4F4E4D4C, 4'hF);
        xfer("range_ok", 10020, 16, 8'h40, 1'b0, 1'b0, 4);

        push(0, 32'h04030201, 4'hF);
        push(1, 32'h08070605, 4'hF);
        xfer("gaps_c8", 0, 8, 8'h01, 1'b1, 1'b0, 2);

        push(10, 32'h14131211, 4'hF);
        push(11, 32'h00000015, 4'h1);
        xfer("gaps_c5", 10, 5, 8'h11, 1'b1, 1'b0, 2);

        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        base_addr = ADDR_W'(5);
        byte_count = 16'd4;
        @(negedge clk);
        start = 1'b0;
        send_bytes(2, 8'h21, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_flags", {25'd0, st_ready, mem_chipselect, mem_write, busy, done, error, mem_clken}, 32'd0);
        chk("midreset_addr", 32'(mem_address), 32'd0);
        chk("midreset_be", 32'(mem_byteenable), 32'd0);
        chk("midreset_data", mem_writedata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("midreset_no_write", 32'(wr_cnt - w0), 32'd0);

        push(3, 32'h34333231, 4'hF);
        xfer("after_reset", 3, 4, 8'h31, 1'b0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_to_mem_writer.md
STREAM_TO_MEM_WRITER -- requirements
Module: stream_to_mem_writer

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the on-chip memory slave driven.
REQ-002 Parameter DEPTH, default 10024, number of 32-bit words in the target memory.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first word address, captured on accepted start.
REQ-007 byte_count  input  16  transfer length in bytes, captured on accepted start.
REQ-008 st_data  input  8  streaming byte.
REQ-009 st_valid  input  1  st_data valid.
REQ-010 st_ready  output  1  byte accepted on a cycle with st_valid=1 and st_ready=1.
REQ-011 mem_address  output  ADDR_W  word address to memory.
REQ-012 mem_byteenable  output  4  lane enables; bit i = writedata[8i+7:8i].
REQ-013 mem_chipselect  output  1  memory select.
REQ-014 mem_write  output  1  write strobe; no waitrequest, every asserted cycle is one completed write.
REQ-015 mem_writedata  output  32  packed write word.
REQ-016 mem_clken  output  1  memory clock enable; constant 1 after reset release.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at transfer end (normal or error).
REQ-019 error  output  1  range error flag, sticky until next accepted start.

Function
REQ-020 FSM states IDLE, FILL, WRITE, FINISH.
REQ-021 IDLE: start=1 captures base_addr, byte_count, clears error; start while not IDLE ignored.
REQ-022 Range check on start: words = ceil(byte_count/4), computed 17-bit; if base_addr+words > DEPTH -> FINISH with error=1, zero memory writes.
REQ-023 byte_count=0 on start -> FINISH, error=0, zero memory writes.
REQ-024 Otherwise IDLE -> FILL, lane counter = 0, word address = base_addr, remaining = byte_count.
REQ-025 FILL: st_ready=1; each accepted byte placed in lane = lane counter (little-endian), its byteenable bit set, lane counter +1, remaining -1.
REQ-026 FILL -> WRITE after accepting lane-3 byte or the byte that makes remaining 0.
REQ-027 WRITE: exactly one cycle, mem_chipselect=mem_write=1, st_ready=0; mem_writedata unused lanes = 0; mem_byteenable = collected lanes only.
REQ-028 Write latency: write cycle is the cycle immediately after the completing byte is accepted.
REQ-029 WRITE exit: remaining>0 -> FILL, word address +1, lane counter 0, pack register and enables cleared; remaining=0 -> FINISH.
REQ-030 FINISH: done=1 for one cycle, then IDLE.
REQ-031 Word address never wraps; guaranteed by REQ-022.
REQ-032 mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write are registered outputs; strobes 0 outside WRITE.
REQ-033 st_valid gaps in FILL stall packing without timeout; no partial-word flush until length satisfied.

Reset
REQ-034 reset_n=0 forces IDLE asynchronously: st_ready, mem_chipselect, mem_write, busy, done, error, mem_clken = 0; mem_address, mem_byteenable, mem_writedata, counters, pack register = 0.
REQ-035 Reset mid-transfer discards partial word; no write issued for it; after release, next start runs normally.

Verification
REQ-036 base 0, count 8, bytes 0x01..0x08 back-to-back -> writes addr 0 data 0x04030201 be 0xF, addr 1 data 0x08070605 be 0xF, one done pulse, error 0.
REQ-037 base 10, count 5, bytes 0x11..0x15 -> addr 10 data 0x14131211 be 0xF, addr 11 data 0x00000015 be 0x1, done.
REQ-038 count 0 -> done pulse two cycles after start, no mem_write, error 0.
REQ-039 base 10020, count 20 (5 words) -> error=1, done pulse, no mem_write; base 10020 count 16 -> 4 writes, last addr 10023, error 0.
REQ-040 st_valid held 1 throughout -> st_ready 0 exactly in each WRITE cycle, no byte lost or duplicated; random st_valid gaps -> identical memory contents.
REQ-041 reset_n pulsed low after 2 of 4 bytes -> all outputs 0 immediately, no write; new start base 3 count 4 -> single write addr 3 be 0xF.
